// File: rtl/skew_inbuf_bank.sv
// Bank of NLANES circular FIFOs feeding one PE-array edge; lane k starts with k*SKEW
// zero words so the array sees a diagonal input skew. Row-wide push/pop, sticky overflow.

module skew_inbuf_lane #(
  parameter int WORDLEN = 8,
  parameter int DEPTH   = 16,
  parameter int PAD     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               push_i,
  input  logic               rd_en_i,
  input  logic [WORDLEN-1:0] wr_word_i,
  output logic [WORDLEN-1:0] rd_word_o,
  output logic               empty_o,
  output logic               full_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] TAIL0 = PW'(PAD % DEPTH);
  localparam logic [CW-1:0] CNT0  = CW'(PAD);

  logic [WORDLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pop, store;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign pop     = rd_en_i & ~empty_o;
  // An empty lane that is read while being written forwards the word instead of storing it.
  assign store   = push_i & ~(empty_o & rd_en_i);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop)   head_d = (head_q == PLAST) ? '0 : head_q + PW'(1);
    if (store) tail_d = (tail_q == PLAST) ? '0 : tail_q + PW'(1);
    case ({store, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    rd_word_o = '0;
    if (!empty_o)               rd_word_o = mem_q[head_q];
    else if (rd_en_i && push_i) rd_word_o = wr_word_i;
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= TAIL0;
      cnt_q  <= CNT0;
    end else begin
      if (store) mem_q[tail_q] <= wr_word_i;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module skew_inbuf_bank #(
  parameter int WORDLEN = 8,
  parameter int DEPTH   = 16,
  parameter int NLANES  = 4,
  parameter int SKEW    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      restart,
  input  logic                      wr_en,
  input  logic [NLANES*WORDLEN-1:0] wr_data,
  output logic                      wr_ready,
  input  logic                      rd_en,
  output logic [NLANES*WORDLEN-1:0] rd_data,
  output logic [NLANES-1:0]         empty,
  output logic [NLANES-1:0]         full,
  output logic                      ovf
);
  logic accept, ovf_q, ovf_d;

  // Ready comes from pre-cycle fullness only; a same-cycle pop never frees a slot.
  assign wr_ready = ~|full;
  assign accept   = wr_en & wr_ready & ~rst & ~restart;
  assign ovf_d    = ovf_q | (wr_en & ~wr_ready);
  assign ovf      = ovf_q;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    skew_inbuf_lane #(
      .WORDLEN(WORDLEN),
      .DEPTH  (DEPTH),
      .PAD    (k * SKEW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .restart  (restart),
      .push_i   (accept),
      .rd_en_i  (rd_en),
      .wr_word_i(wr_data[k*WORDLEN +: WORDLEN]),
      .rd_word_o(rd_data[k*WORDLEN +: WORDLEN]),
      .empty_o  (empty[k]),
      .full_o   (full[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)           ovf_q <= 1'b0;
    else if (!restart) ovf_q <= ovf_d;
  end
endmodule
